counter_cmd_sched: RTL and testbench
====================================

// Module: counter_cmd_sched
// PURPOSE
//  Command scheduler for one shared 8-bit event counter. Merges single-cycle host trigger
//  pulses (clear/up/down, from okTriggerIn bits) with an internal prescaled autocount tick.
//  Simultaneous commands are held pending, not dropped; exactly one op is applied per cycle.
//  Count and event pulses feed okWireOut/okTriggerOut endpoints in the sys_clk domain.
// PARAMETERS
//  DIV_W    24      prescaler width; tick period = div_cfg+1 cycles
//  CNT_W    8       counter width; events decode 0, 2^(CNT_W-1), 2^CNT_W-1
// PORTS
//  sys_clk      in   1       sole clock; all logic posedge sys_clk
//  reset_n      in   1       synchronous, active-low reset
//  req_clr      in   1       clear request pulse (1 cycle)
//  req_up       in   1       increment request pulse
//  req_down     in   1       decrement request pulse
//  en           in   1       0 = hold: no ops except clear; pendings retained; prescaler frozen
//  autocount    in   1       1 = prescaler tick generates auto-increment requests
//  div_cfg      in   DIV_W   prescaler reload value, sampled at each reload
//  count        out  CNT_W   current counter value
//  evt_zero     out  1       1-cycle pulse: an applied op left count==0
//  evt_half     out  1       1-cycle pulse: an applied op left count==2^(CNT_W-1)
//  evt_max      out  1       1-cycle pulse: an applied op left count==all-ones
//  wrap         out  1       1-cycle pulse: up/auto FF->00 or down 00->FF occurred
//  pend         out  3       pending flags {auto,down,up}
//  lost         out  1       sticky: request arrived while same source already pending
// BEHAVIOUR
//  Reset (reset_n=0 at edge): count=0, all pend=0, lost=0, evt_*/wrap=0, rr pointer=up,
//   prescaler loads div_cfg. Reset mid-operation discards all pendings; no events generated.
//  Prescaler: when en=1, down-counts; at 0 emits tick (1 cycle) and reloads div_cfg. div_cfg=0
//   -> tick every cycle. Tick raises auto request only when autocount=1; otherwise ignored.
//  Effective request per source = incoming pulse OR pend bit.
//  Arbitration each cycle (combinational on effective requests, result at same edge):
//   1. clear effective -> count<=0; pend cleared to 0 (same-cycle up/down/auto discarded);
//      lost<=0. Clear honoured even when en=0.
//   2. else if en=1: round-robin among up, down, auto starting at rr pointer; granted op
//      applied; rr pointer <= source after granted one (up->down->auto->up).
//   3. non-granted effective requests set/keep their pend bit; granted source's pend cleared.
//  Latency: pulse sampled at edge k with nothing pending -> count updated at edge k.
//  Arithmetic: modulo 2^CNT_W; up/auto +1, down -1; wrap pulse on rollover either direction.
//  Events: evt_* and wrap registered from the applied op; asserted for one cycle after the
//   edge that applied it. Level is not held: count resting at 0 gives no further evt_zero.
//   Clear applied with count already 0 still pulses evt_zero.
//  lost: set when a pulse arrives on a source whose pend=1 and that source not granted in that
//   cycle; one pending slot per source, extra requests counted as lost, not queued.
//  Up and down pending together: served in rr order, net effect zero over two cycles.
//  en 1->0 with pendings: pendings held; served in rr order after en returns to 1.
// TESTING
//  1. reset_n=0 2 cycles, then req_up x3 single pulses spaced 2 cycles -> count=3, no evt, lost=0.
//  2. req_up & req_down & tick same cycle, rr=up -> up applied, pend=3'b110; next 2 cycles
//     down then auto applied; final count=start+1; pend=0.
//  3. count=8'hFF, req_up -> count=0, wrap=1 and evt_zero=1 for exactly one cycle; then
//     req_down -> count=FF, wrap=1, evt_max=1.
//  4. req_up+req_down pending, then req_clr -> count=0, pend=0, lost=0, evt_zero pulse.
//  5. div_cfg=3, autocount=1, en=1 -> count increments every 4 cycles; en=0 -> count frozen,
//     req_up pulses pend up; second req_up while pending -> lost=1; en=1 -> one increment.
//  6. reset_n=0 asserted with pend=3'b111, count=8'h7F -> next cycle count=0, pend=0,
//     no evt_* or wrap pulse.

Source files
------------

// File: rtl/counter_cmd_sched.sv
// Command scheduler for a shared event counter: merges clear/up/down host pulses with a
// prescaled auto-increment tick, holding colliding requests pending and applying one op per cycle.
module counter_cmd_sched #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             sys_clk_i,
  input  logic             reset_n_i,
  input  logic             req_clr_i,
  input  logic             req_up_i,
  input  logic             req_down_i,
  input  logic             en_i,
  input  logic             autocount_i,
  input  logic [DIV_W-1:0] div_cfg_i,
  output logic [CNT_W-1:0] count_o,
  output logic             evt_zero_o,
  output logic             evt_half_o,
  output logic             evt_max_o,
  output logic             wrap_o,
  output logic [2:0]       pend_o,
  output logic             lost_o
);

  // Round-robin pointer: the source checked first in the next arbitration.
  typedef enum logic [1:0] {
    SRC_UP   = 2'd0,
    SRC_DOWN = 2'd1,
    SRC_AUTO = 2'd2
  } src_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_HALF = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic             lost_q, lost_d;
  src_e             rr_q, rr_d;
  logic             evt_zero_q, evt_zero_d;
  logic             evt_half_q, evt_half_d;
  logic             evt_max_q, evt_max_d;
  logic             wrap_q, wrap_d;

  logic       tick;
  logic       applied;
  logic [2:0] pulse;
  logic [2:0] eff;
  logic [2:0] grant;

  always_comb begin
    tick       = en_i && (presc_q == '0);
    presc_d    = presc_q;
    pulse      = {tick & autocount_i, req_down_i, req_up_i};
    eff        = pulse | pend_q;
    grant      = 3'b000;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    lost_d     = lost_q;
    rr_d       = rr_q;
    wrap_d     = 1'b0;
    applied    = 1'b0;

    if (en_i) begin
      presc_d = tick ? div_cfg_i : presc_q - DIV_ONE;
    end

    // Bit order of eff/grant is {auto, down, up}.
    if (!req_clr_i && en_i) begin
      case (rr_q)
        SRC_DOWN: begin
          if (eff[1])      grant = 3'b010;
          else if (eff[2]) grant = 3'b100;
          else if (eff[0]) grant = 3'b001;
        end
        SRC_AUTO: begin
          if (eff[2])      grant = 3'b100;
          else if (eff[0]) grant = 3'b001;
          else if (eff[1]) grant = 3'b010;
        end
        default: begin
          if (eff[0])      grant = 3'b001;
          else if (eff[1]) grant = 3'b010;
          else if (eff[2]) grant = 3'b100;
        end
      endcase
    end

    if (req_clr_i) begin
      cnt_d   = '0;
      pend_d  = 3'b000;
      lost_d  = 1'b0;
      applied = 1'b1;
    end else begin
      pend_d = eff & ~grant;
      lost_d = lost_q | (|(pulse & pend_q & ~grant));
      if (grant[1]) begin
        cnt_d   = cnt_q - CNT_ONE;
        wrap_d  = (cnt_q == '0);
        applied = 1'b1;
        rr_d    = SRC_AUTO;
      end else if (grant[0] || grant[2]) begin
        cnt_d   = cnt_q + CNT_ONE;
        wrap_d  = &cnt_q;
        applied = 1'b1;
        rr_d    = grant[0] ? SRC_DOWN : SRC_UP;
      end
    end

    evt_zero_d = applied && (cnt_d == '0);
    evt_half_d = applied && (cnt_d == CNT_HALF);
    evt_max_d  = applied && (&cnt_d);
  end

  always_ff @(posedge sys_clk_i) begin
    if (!reset_n_i) begin
      presc_q    <= div_cfg_i;
      cnt_q      <= '0;
      pend_q     <= 3'b000;
      lost_q     <= 1'b0;
      rr_q       <= SRC_UP;
      evt_zero_q <= 1'b0;
      evt_half_q <= 1'b0;
      evt_max_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      lost_q     <= lost_d;
      rr_q       <= rr_d;
      evt_zero_q <= evt_zero_d;
      evt_half_q <= evt_half_d;
      evt_max_q  <= evt_max_d;
      wrap_q     <= wrap_d;
    end
  end

  assign count_o    = cnt_q;
  assign evt_zero_o = evt_zero_q;
  assign evt_half_o = evt_half_q;
  assign evt_max_o  = evt_max_q;
  assign wrap_o     = wrap_q;
  assign pend_o     = pend_q;
  assign lost_o     = lost_q;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Directed bench for counter_cmd_sched: hand-computed counts, pend flags, lost and event pulses.
module tb_counter_cmd_sched;

  logic        sys_clk_i = 1'b0;
  logic        reset_n_i;
  logic        req_clr_i, req_up_i, req_down_i, en_i, autocount_i;
  logic [23:0] div_cfg_i;
  logic [7:0]  count_o;
  logic        evt_zero_o, evt_half_o, evt_max_o, wrap_o;
  logic [2:0]  pend_o;
  logic        lost_o;

  int total = 0;
  int bad   = 0;

  counter_cmd_sched #(.DIV_W(24), .CNT_W(8)) dut (
    .sys_clk_i   (sys_clk_i),
    .reset_n_i   (reset_n_i),
    .req_clr_i   (req_clr_i),
    .req_up_i    (req_up_i),
    .req_down_i  (req_down_i),
    .en_i        (en_i),
    .autocount_i (autocount_i),
    .div_cfg_i   (div_cfg_i),
    .count_o     (count_o),
    .evt_zero_o  (evt_zero_o),
    .evt_half_o  (evt_half_o),
    .evt_max_o   (evt_max_o),
    .wrap_o      (wrap_o),
    .pend_o      (pend_o),
    .lost_o      (lost_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // One clock with the given inputs held; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic clr, input logic up, input logic dn, input logic e,
                      input logic ac);
    req_clr_i   = clr;
    req_up_i    = up;
    req_down_i  = dn;
    en_i        = e;
    autocount_i = ac;
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected event vector is {evt_zero, evt_half, evt_max, wrap}.
  task automatic chk_evt(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, evt_zero_o, evt_half_o, evt_max_o, wrap_o}, {28'd0, exp});
  endtask

  int exp_auto [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};

  initial begin
    reset_n_i = 1'b0;
    div_cfg_i = 24'd0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("rst_count", count_o, 0);
    chk("rst_pend", pend_o, 0);
    chk("rst_lost", lost_o, 0);
    chk_evt("rst_evt", 4'b0000);
    reset_n_i = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 1, 0);
      chk("t1_count", count_o, i);
      chk_evt("t1_evt", 4'b0000);
      step(0, 0, 0, 1, 0);
      chk_evt("t1_evt_idle", 4'b0000);
    end
    chk("t1_lost", lost_o, 0);

    // Lone auto request moves the rr pointer back to up.
    step(0, 0, 0, 1, 1);
    chk("t2_pre_count", count_o, 4);

    step(0, 1, 1, 1, 1);
    chk("t2_up_count", count_o, 5);
    chk("t2_up_pend", pend_o, 3'b110);
    step(0, 0, 0, 1, 0);
    chk("t2_down_count", count_o, 4);
    chk("t2_down_pend", pend_o, 3'b100);
    step(0, 0, 0, 1, 0);
    chk("t2_auto_count", count_o, 5);
    chk("t2_auto_pend", pend_o, 3'b000);
    chk("t2_lost", lost_o, 0);

    step(1, 0, 0, 1, 0);
    chk("t3_clr_count", count_o, 0);
    chk_evt("t3_clr_evt", 4'b1000);
    step(0, 0, 1, 1, 0);
    chk("t3_dn_count", count_o, 8'hFF);
    chk_evt("t3_dn_evt", 4'b0011);
    step(0, 1, 0, 1, 0);
    chk("t3_up_wrap_count", count_o, 0);
    chk_evt("t3_up_wrap_evt", 4'b1001);
    step(0, 0, 0, 1, 0);
    chk("t3_idle_count", count_o, 0);
    chk_evt("t3_idle_evt", 4'b0000);
    step(0, 0, 1, 1, 0);
    chk("t3_dn_wrap_count", count_o, 8'hFF);
    chk_evt("t3_dn_wrap_evt", 4'b0011);
    step(0, 0, 0, 1, 0);
    chk_evt("t3_idle2_evt", 4'b0000);

    step(0, 1, 1, 0, 0);
    chk("t4_hold_count", count_o, 8'hFF);
    chk("t4_hold_pend", pend_o, 3'b011);
    chk("t4_hold_lost", lost_o, 0);
    step(0, 1, 0, 0, 0);
    chk("t4_lost_set", lost_o, 1);
    chk("t4_lost_pend", pend_o, 3'b011);
    step(1, 0, 0, 0, 0);
    chk("t4_clr_count", count_o, 0);
    chk("t4_clr_pend", pend_o, 0);
    chk("t4_clr_lost", lost_o, 0);
    chk_evt("t4_clr_evt", 4'b1000);

    div_cfg_i = 24'd3;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 1, 1);
      chk("t5_auto_count", count_o, exp_auto[i]);
    end
    step(0, 1, 0, 0, 1);
    chk("t5_hold_count", count_o, 3);
    chk("t5_hold_pend", pend_o, 3'b001);
    chk("t5_hold_lost", lost_o, 0);
    step(0, 1, 0, 0, 1);
    chk("t5_lost_set", lost_o, 1);
    chk("t5_lost_pend", pend_o, 3'b001);
    step(0, 0, 0, 0, 1);
    chk("t5_frozen_count", count_o, 3);
    step(0, 0, 0, 1, 0);
    chk("t5_resume_count", count_o, 4);
    chk("t5_resume_pend", pend_o, 0);
    chk("t5_lost_sticky", lost_o, 1);
    step(0, 0, 0, 1, 0);
    chk("t5_single_inc", count_o, 4);

    div_cfg_i = 24'd0;
    step(1, 0, 0, 1, 0);
    chk("t6_clr_count", count_o, 0);
    chk("t6_clr_lost", lost_o, 0);
    for (int i = 0; i < 128; i++) step(0, 1, 0, 1, 0);
    chk("t6_half_count", count_o, 8'h80);
    chk_evt("t6_half_evt", 4'b0100);
    step(0, 1, 1, 1, 1);
    chk("t6_rr_down_count", count_o, 8'h7F);
    chk("t6_rr_down_pend", pend_o, 3'b101);
    chk_evt("t6_rr_down_evt", 4'b0000);
    step(0, 0, 1, 0, 0);
    chk("t6_pend_all", pend_o, 3'b111);
    chk("t6_pend_all_count", count_o, 8'h7F);
    reset_n_i = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("t6_rst_count", count_o, 0);
    chk("t6_rst_pend", pend_o, 0);
    chk("t6_rst_lost", lost_o, 0);
    chk_evt("t6_rst_evt", 4'b0000);
    reset_n_i = 1'b1;
    step(0, 0, 0, 1, 0);
    chk("t6_post_count", count_o, 0);
    chk("t6_post_pend", pend_o, 0);
    chk_evt("t6_post_evt", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
